// File: rtl/word_unit_pkg.sv
// word_unit_pkg: shared FSM state type and parameter defaults
package word_unit_pkg;
  localparam int WORD_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam bit MSB_FIRST_DEF = 1'b1;
  localparam bit PARITY_EN_DEF = 1'b0;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} tx_state_t;
endpackage

// File: rtl/word_unit_fifo.sv
// word_unit_fifo: synchronous DEPTH x WORD_W word buffer with occupancy count
module word_unit_fifo import word_unit_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WORD_W-1:0]          push_data,
  input  logic                       pop,
  output logic [WORD_W-1:0]          pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign pop_data = mem[rd_ptr];
  // storage needs no reset: pointers and count alone define valid contents
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/word_unit.sv
// word_unit: serial bits -> buffered words -> serial bits with optional even parity
module word_unit import word_unit_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_DEF,
  parameter bit PARITY_EN = PARITY_EN_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sema_valid_i,
  input  logic                       sema_data_i,
  output logic                       sema_ready_o,
  input  logic                       sema_is_empty_i,
  output logic                       sema_write_o,
  output logic                       sema_data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int CW = $clog2(WORD_W);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST = CW'(WORD_W-1);
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [WORD_W-1:0] rx_sh, rx_word, tx_sh, pop_data;
  logic accept, push, pop, tx_bit, last_bit;
  tx_state_t state, state_nxt;
  // a partial word may keep collecting while full; only its final bit stalls
  assign sema_ready_o = rx_cnt != LAST || level_o != LW'(DEPTH);
  assign accept = sema_valid_i && sema_ready_o;
  assign push = accept && rx_cnt == LAST;
  assign rx_word = MSB_FIRST ? {rx_sh[WORD_W-2:0], sema_data_i} : {sema_data_i, rx_sh[WORD_W-1:1]};
  assign tx_bit = MSB_FIRST ? tx_sh[LAST - tx_cnt] : tx_sh[tx_cnt];
  word_unit_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(rx_word),
    .pop(pop),
    .pop_data(pop_data),
    .count(level_o)
  );
  // input side: assemble bits, push the completed word on its last bit
  always_ff @(posedge clk)
    if (rst) begin
      rx_cnt <= '0;
      rx_sh <= '0;
    end else if (accept) begin
      rx_cnt <= push ? '0 : rx_cnt + 1'b1;
      rx_sh <= rx_word;
    end
  // output FSM: pop when idle, reload right after the last written bit
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    sema_write_o = 1'b0;
    sema_data_o = 1'b0;
    last_bit = 1'b0;
    if (state == IDLE) begin
      pop = level_o != '0;
      state_nxt = pop ? SHIFT : IDLE;
    end else begin
      sema_write_o = sema_is_empty_i;
      sema_data_o = sema_is_empty_i && (state == PARITY ? ^tx_sh : tx_bit);
      last_bit = sema_write_o && (state == PARITY || (tx_cnt == LAST && !PARITY_EN));
      state_nxt = (sema_write_o && state == SHIFT && tx_cnt == LAST && PARITY_EN) ? PARITY : state;
      if (last_bit) begin
        pop = level_o != '0;
        state_nxt = pop ? SHIFT : IDLE;
      end
    end
  end
  // output state, word register and bit counter
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx_sh <= '0;
      tx_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        tx_sh <= pop_data;
        tx_cnt <= '0;
      end else if (sema_write_o && state == SHIFT) tx_cnt <= tx_cnt + 1'b1;
    end
endmodule

// File: tb/tb_word_unit.sv
// tb_word_unit: random and directed checks of word_unit against a word-stream model
module tb_word_unit;
  localparam int W = 8;
  localparam int D = 4;
  localparam int NI = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic is_empty = 1'b1;
  logic vall = 1'b0;
  logic [NI-1:0] valid = '0;
  logic [NI-1:0] din = '0;
  logic [NI-1:0] ready, write, dout;
  logic [2:0] lvl [NI];
  logic [7:0] words[$];
  int widx[NI], bidx[NI], owidx[NI], obidx[NI];
  int first_wr[NI], last_wr[NI], n_wr[NI], last_acc[NI];
  int edges = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  word_unit #(.WORD_W(W), .DEPTH(D), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_msb (
    .clk(clk), .rst(rst), .sema_valid_i(valid[0]), .sema_data_i(din[0]), .sema_ready_o(ready[0]),
    .sema_is_empty_i(is_empty), .sema_write_o(write[0]), .sema_data_o(dout[0]), .level_o(lvl[0]));
  word_unit #(.WORD_W(W), .DEPTH(D), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sema_valid_i(valid[1]), .sema_data_i(din[1]), .sema_ready_o(ready[1]),
    .sema_is_empty_i(is_empty), .sema_write_o(write[1]), .sema_data_o(dout[1]), .level_o(lvl[1]));
  word_unit #(.WORD_W(W), .DEPTH(D), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
    .clk(clk), .rst(rst), .sema_valid_i(valid[2]), .sema_data_i(din[2]), .sema_ready_o(ready[2]),
    .sema_is_empty_i(is_empty), .sema_write_o(write[2]), .sema_data_o(dout[2]), .level_o(lvl[2]));

  // serial bit b of word w as seen on the wire of instance i (b == W is the parity slot)
  function automatic logic bitof(input int i, input logic [7:0] w, input int b);
    if (b == W) return ^w;
    return (i == 1) ? w[b] : w[W-1-b];
  endfunction

  function automatic int nbits(input int i);
    return (i == 2) ? W + 1 : W;
  endfunction

  function automatic bit all_done();
    for (int i = 0; i < NI; i++) if (owidx[i] != words.size()) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    words.delete();
    for (int i = 0; i < NI; i++) begin
      widx[i] = 0; bidx[i] = 0; owidx[i] = 0; obidx[i] = 0;
      first_wr[i] = -1; last_wr[i] = -1; n_wr[i] = 0; last_acc[i] = -1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    vall = 1'b0;
    valid = '0;
    din = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    clear_model();
    for (int i = 0; i < NI; i++) begin
      chk(lvl[i], 0, "rst_level");
      chk(ready[i], 1, "rst_ready");
      chk(write[i], 0, "rst_write");
      chk(dout[i], 0, "rst_data");
    end
    rst = 1'b0;
  endtask

  // one clock: drive inputs, check outputs against the model, advance the model
  task automatic step();
    logic [NI-1:0] acc, wr;
    for (int i = 0; i < NI; i++) begin
      valid[i] = vall && widx[i] < words.size();
      din[i] = valid[i] ? bitof(i, words[widx[i]], bidx[i]) : 1'b0;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      if (write[i] && owidx[i] < widx[i]) chk(dout[i], bitof(i, words[owidx[i]], obidx[i]), "data");
      else if (write[i]) chk(write[i], 0, "spurious_write");
      else chk(dout[i], 0, "idle_data");
      if (!is_empty) chk(write[i], 0, "write_no_room");
    end
    acc = valid & ready;
    wr = write;
    @(posedge clk);
    edges++;
    for (int i = 0; i < NI; i++) begin
      if (acc[i]) begin
        bidx[i]++;
        if (bidx[i] == W) begin
          bidx[i] = 0;
          widx[i]++;
          last_acc[i] = edges;
        end
      end
      if (wr[i]) begin
        if (first_wr[i] < 0) first_wr[i] = edges;
        last_wr[i] = edges;
        n_wr[i]++;
        obidx[i]++;
        if (obidx[i] == nbits(i)) begin
          obidx[i] = 0;
          owidx[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until_done(input int bound);
    for (int k = 0; k < bound && !all_done(); k++) step();
    for (int i = 0; i < NI; i++) chk(owidx[i], words.size(), "drained");
  endtask

  initial begin
    do_reset(2);
    // single word 0xA5, free-flowing output: order and two-cycle latency
    is_empty = 1'b1;
    vall = 1'b1;
    words.push_back(8'hA5);
    run_until_done(60);
    for (int i = 0; i < NI; i++) begin
      chk(first_wr[i] - last_acc[i], 2, "latency");
      chk(n_wr[i], nbits(i), "bit_count");
    end
    // parity slot: 0x07 has odd weight, 0x03 even
    do_reset(1);
    is_empty = 1'b1;
    vall = 1'b1;
    words.push_back(8'h07);
    words.push_back(8'h03);
    run_until_done(80);
    chk(n_wr[2], 2 * (W + 1), "parity_bits");
    chk(last_wr[2] - first_wr[2] + 1, n_wr[2], "parity_contiguous");
    // backpressure: one word in the output register, four buffered, sixth stalls on its last bit
    do_reset(1);
    is_empty = 1'b0;
    vall = 1'b1;
    for (int k = 0; k < 6; k++) words.push_back(8'($urandom));
    for (int k = 0; k < 200 && !(widx[0] == 5 && bidx[0] == 7); k++) step();
    for (int i = 0; i < NI; i++) begin
      chk(lvl[i], D, "full_level");
      chk(ready[i], 0, "full_ready");
    end
    is_empty = 1'b1;
    for (int k = 0; k < 12 && !ready[0]; k++) step();
    chk(ready[0], 1, "ready_recover");
    run_until_done(300);
    for (int i = 0; i < NI; i++) begin
      chk(last_wr[i] - first_wr[i] + 1, n_wr[i], "back_to_back");
      chk(lvl[i], 0, "empty_after");
    end
    // random valid / downstream room
    do_reset(1);
    for (int k = 0; k < 20; k++) words.push_back(8'($urandom));
    for (int k = 0; k < 3000 && !all_done(); k++) begin
      vall = ($urandom % 4) != 0;
      is_empty = ($urandom % 3) != 0;
      step();
    end
    for (int i = 0; i < NI; i++) begin
      chk(owidx[i], words.size(), "rand_drained");
      chk(lvl[i], 0, "rand_level");
    end
    // reset mid-word on both sides, then a clean word
    do_reset(1);
    is_empty = 1'b1;
    vall = 1'b1;
    words.push_back(8'($urandom));
    words.push_back(8'($urandom));
    for (int k = 0; k < 40 && obidx[0] < 3; k++) step();
    chk(obidx[0], 3, "mid_output");
    do_reset(1);
    is_empty = 1'b1;
    vall = 1'b1;
    words.push_back(8'h3C);
    run_until_done(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
